// File: rtl/multi_dataflow_ctrl_fsm_mc.sv
// Multi-channel job sequencer for the multi_dataflow HWPE: per-channel start/done tracking,
// per-sink saturating word counters. Optional watchdog under MULTI_DATAFLOW_CTRL_TIMEOUT_EN.
module multi_dataflow_ctrl_fsm_mc #(
  parameter int N_IN        = 1,
  parameter int N_OUT       = 1,
  parameter int CNT_W       = 11,
  parameter int ITER_W      = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [ITER_W-1:0]      nb_iter_i,
  input  logic [CNT_W-1:0]       cnt_limit_i,
  output logic [N_IN-1:0]        src_start_o,
  input  logic [N_IN-1:0]        src_done_i,
  output logic [N_OUT-1:0]       sink_start_o,
  input  logic [N_OUT-1:0]       sink_done_i,
  input  logic [N_OUT-1:0]       out_hs_i,
  output logic                   engine_start_o,
  output logic [N_OUT*CNT_W-1:0] cnt_o,
  output logic [N_OUT-1:0]       cnt_reached_o,
  output logic [ITER_W-1:0]      iter_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_COMPUTE  = 3'd2,
    S_UPDATE   = 3'd3,
    S_FINISHED = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [ITER_W-1:0]      nb_iter_q, nb_iter_d, iter_q, iter_d;
  logic [CNT_W-1:0]       lim_q, lim_d;
  logic [N_OUT*CNT_W-1:0] cnt_q, cnt_d;
  logic [N_OUT-1:0]       reached_q, reached_d, sink_flag_q, sink_flag_d;
  logic [N_OUT-1:0]       sink_start_q, sink_start_d;
  logic [N_IN-1:0]        src_flag_q, src_flag_d, src_start_q, src_start_d;
  logic                   eng_start_q, eng_start_d, busy_q, busy_d, done_q, done_d;
  logic                   all_done_s;
`ifdef MULTI_DATAFLOW_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   err_q, err_d;
  logic                   activity_s;
`endif

  // Next-state, counters, flags and registered-output decode
  always_comb begin
    state_d     = state_q;
    nb_iter_d   = nb_iter_q;
    iter_d      = iter_q;
    lim_d       = lim_q;
    cnt_d       = cnt_q;
    src_flag_d  = src_flag_q;
    sink_flag_d = sink_flag_q;
    all_done_s  = (&(src_flag_q | src_done_i)) & (&(sink_flag_q | sink_done_i));
`ifdef MULTI_DATAFLOW_CTRL_TIMEOUT_EN
    wd_d       = wd_q;
    err_d      = err_q;
    activity_s = (|out_hs_i) | (|src_done_i) | (|sink_done_i);
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          nb_iter_d = nb_iter_i;
          lim_d     = cnt_limit_i;
          iter_d    = '0;
`ifdef MULTI_DATAFLOW_CTRL_TIMEOUT_EN
          err_d     = 1'b0;
`endif
          if (nb_iter_i == '0) begin
            state_d = S_FINISHED;
          end else begin
            state_d = S_START;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        cnt_d       = '0;
        src_flag_d  = '0;
        sink_flag_d = '0;
`ifdef MULTI_DATAFLOW_CTRL_TIMEOUT_EN
        wd_d        = '0;
`endif
        state_d     = S_COMPUTE;
      end
      S_COMPUTE: begin
        src_flag_d  = src_flag_q | src_done_i;
        sink_flag_d = sink_flag_q | sink_done_i;
        for (int j = 0; j < N_OUT; j++) begin
          if (out_hs_i[j] && (cnt_q[j*CNT_W +: CNT_W] < lim_q)) begin
            cnt_d[j*CNT_W +: CNT_W] = cnt_q[j*CNT_W +: CNT_W] + CNT_W'(1);
          end else begin
            cnt_d[j*CNT_W +: CNT_W] = cnt_q[j*CNT_W +: CNT_W];
          end
        end
        if (all_done_s) begin
          state_d = S_UPDATE;
        end else begin
`ifdef MULTI_DATAFLOW_CTRL_TIMEOUT_EN
          // wd_q holds the idle cycles seen before this one
          if (activity_s) begin
            wd_d    = '0;
            state_d = S_COMPUTE;
          end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            wd_d    = '0;
            err_d   = 1'b1;
            state_d = S_FINISHED;
          end else begin
            wd_d    = wd_q + WD_W'(1);
            state_d = S_COMPUTE;
          end
`else
          state_d = S_COMPUTE;
`endif
        end
      end
      S_UPDATE: begin
        iter_d = iter_q + ITER_W'(1);
        if (iter_d == nb_iter_q) begin
          state_d = S_FINISHED;
        end else begin
          state_d = S_START;
        end
      end
      S_FINISHED: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Limit flags follow the counters only while a job is counting, otherwise hold
    for (int j = 0; j < N_OUT; j++) begin
      if ((state_q == S_START) || (state_q == S_COMPUTE)) begin
        reached_d[j] = (cnt_d[j*CNT_W +: CNT_W] == lim_d);
      end else begin
        reached_d[j] = reached_q[j];
      end
    end
    src_start_d  = {N_IN{state_d == S_START}};
    sink_start_d = {N_OUT{state_d == S_START}};
    eng_start_d  = (state_d == S_START);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FINISHED);
  end

  // State and output registers with async reset and synchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      nb_iter_q    <= '0;
      iter_q       <= '0;
      lim_q        <= '0;
      cnt_q        <= '0;
      reached_q    <= '0;
      src_flag_q   <= '0;
      sink_flag_q  <= '0;
      src_start_q  <= '0;
      sink_start_q <= '0;
      eng_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MULTI_DATAFLOW_CTRL_TIMEOUT_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else if (clear_i) begin
      state_q      <= S_IDLE;
      nb_iter_q    <= '0;
      iter_q       <= '0;
      lim_q        <= '0;
      cnt_q        <= '0;
      reached_q    <= '0;
      src_flag_q   <= '0;
      sink_flag_q  <= '0;
      src_start_q  <= '0;
      sink_start_q <= '0;
      eng_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MULTI_DATAFLOW_CTRL_TIMEOUT_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      nb_iter_q    <= nb_iter_d;
      iter_q       <= iter_d;
      lim_q        <= lim_d;
      cnt_q        <= cnt_d;
      reached_q    <= reached_d;
      src_flag_q   <= src_flag_d;
      sink_flag_q  <= sink_flag_d;
      src_start_q  <= src_start_d;
      sink_start_q <= sink_start_d;
      eng_start_q  <= eng_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef MULTI_DATAFLOW_CTRL_TIMEOUT_EN
      wd_q         <= wd_d;
      err_q        <= err_d;
`endif
    end
  end

  assign src_start_o    = src_start_q;
  assign sink_start_o   = sink_start_q;
  assign engine_start_o = eng_start_q;
  assign cnt_o          = cnt_q;
  assign cnt_reached_o  = reached_q;
  assign iter_o         = iter_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
`ifdef MULTI_DATAFLOW_CTRL_TIMEOUT_EN
  assign err_o          = err_q;
`else
  assign err_o          = 1'b0;
`endif

endmodule
